p4_egress_demux: RTL
====================

# p4_egress_demux

Receive-side companion to the `vitis_net_p4_0` packet-split pipeline: it sinks the core's output AXI-Stream together with its `user_metadata_out` and steers each packet to one of `NUM_PORTS` egress AXI-Stream ports. The egress port is selected by the packet's metadata word. Packets whose metadata names a non-existent port are discarded and counted. Metadata words are buffered in a small FIFO, because the core issues them without backpressure and independently of data-beat timing.

## Interface
- `TDATA_NUM_BYTES`, 64, bytes per data beat.
- `USER_META_DATA_WIDTH`, 9, metadata width; the unsigned value is the egress port index.
- `NUM_PORTS`, 2, number of egress ports (1..8).
- `META_FIFO_DEPTH`, 4, metadata FIFO entries; must be a power of 2, ≥2.

Ports (clock and reset first):
- `s_axis_aclk`  in  1  sole clock; all logic samples on its rising edge.
- `s_axis_aresetn`  in  1  reset: one clock; synchronous, active-low.
- `user_metadata_in`  in  `USER_META_DATA_WIDTH`  per-packet metadata from the core.
- `user_metadata_in_valid`  in  1  one-cycle qualifier; one pulse per packet.
- `s_axis_tdata`  in  `TDATA_NUM_BYTES*8`  packet data from the core.
- `s_axis_tkeep`  in  `TDATA_NUM_BYTES`  byte enables.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tready`  out  1  beat accept.
- `m_axis_tdata`  out  `NUM_PORTS*TDATA_NUM_BYTES*8`  port i occupies slice `[i*TDATA_NUM_BYTES*8 +: TDATA_NUM_BYTES*8]`.
- `m_axis_tkeep`  out  `NUM_PORTS*TDATA_NUM_BYTES`  per-port byte enables, same slicing scheme.
- `m_axis_tvalid`  out  `NUM_PORTS`  per-port valid.
- `m_axis_tlast`  out  `NUM_PORTS`  per-port last.
- `m_axis_tready`  in  `NUM_PORTS`  per-port ready.
- `drop_count`  out  32  packets discarded; saturates at 0xFFFFFFFF.
- `meta_overflow`  out  1  sticky flag: a metadata word was lost because the FIFO was full.

## Operation
- **Metadata FIFO.**
  - Push on `user_metadata_in_valid`.
  - Pop only in IDLE.
  - Push while full with no simultaneous pop: the word is discarded and `meta_overflow` is set. It clears only on reset.
  - Push and pop in the same cycle: both take effect, including when the FIFO is full.
  - A word pushed in cycle N is visible to IDLE in cycle N+1; there is no fall-through.
- **FSM states: IDLE, FWD, DROP.**
  - **IDLE:**
    - `s_axis_tready`=0.
    - If the FIFO is non-empty: pop and latch `sel` = popped word.
    - If `sel` < `NUM_PORTS`, go to FWD; otherwise go to DROP.
    - If the FIFO is empty, stay in IDLE.
  - **FWD:**
    - `s_axis_tready` = `m_axis_tready[sel]`.
    - `m_axis_tvalid[sel]` = `s_axis_tvalid`; all other valids are 0.
    - `tdata`, `tkeep` and `tlast` are replicated combinationally to every port slice. Only the valids are gated.
    - When a beat with `tlast`=1 is accepted (`s_axis_tvalid` & `s_axis_tready`), go to IDLE.
  - **DROP:**
    - `s_axis_tready`=1; all `m_axis_tvalid`=0.
    - When a `tlast` beat is accepted, increment `drop_count` (saturating) and go to IDLE.
- **Comparison width:** the metadata value is compared as unsigned `USER_META_DATA_WIDTH` bits against `NUM_PORTS`. Values ≥ `NUM_PORTS` are dropped.
- **Ordering:** metadata FIFO order equals packet order, so the k-th metadata word routes the k-th packet.

## Timing
- **Reset values:**
  - State=IDLE, FIFO empty, `sel`=0, `drop_count`=0, `meta_overflow`=0.
  - `s_axis_tready`=0 and all `m_axis_tvalid`=0.
- **Reset mid-packet:** all state is discarded, and remaining beats of that packet stall until new metadata arrives. Recovery is the upstream reset's responsibility.
- **Forwarding latency:** zero cycles in FWD (combinational path).
- **Per-packet overhead:** exactly one IDLE cycle between the accepted `tlast` and the first beat of the next packet.
- **Minimum packet gap:** metadata at cycle N means the first beat can be accepted at N+2 at the earliest (N+1 is the IDLE pop).
- **AXI-Stream rules:**
  - `m_axis_tvalid[sel]` follows `s_axis_tvalid` and is never deasserted by this block mid-beat.
  - A stalled beat holds its data stable because the source holds it.
- **Single-beat packets** (`tlast` on the first beat) are legal in both FWD and DROP.

## Test plan
- **Route to port 1:** metadata 9'd1, then a 3-beat packet with `m_axis_tready`=2'b11. Port 1 sees 3 valid beats with `tlast` on beat 3; port 0 `tvalid` stays 0; `drop_count`=0.
- **Drop:** metadata 9'd5, then a 2-beat packet. `s_axis_tready` is held at 1, no `m_axis_tvalid` asserts, and `drop_count`=1 after `tlast`.
- **Backpressure:** route to port 0 and toggle `m_axis_tready[0]` 1,0,0,1 across a 4-beat packet. `s_axis_tready` mirrors it, there are exactly 4 accepted beats, and data order is preserved.
- **Back-to-back packets:** metadata 0,1,0 pushed on consecutive cycles, then three single-beat packets. Delivery is port0, port1, port0, with one IDLE cycle between each.
- **FIFO overflow:** 5 metadata pulses with no data (depth 4). `meta_overflow`=1; the first 4 words route the next 4 packets and the 5th is lost. Then a push and pop in the same cycle while full leaves the FIFO count unchanged.
- **Reset mid-packet:** assert `s_axis_aresetn`=0 for 1 cycle during beat 2 of a forwarded packet. All outputs return to reset values, the FIFO is empty, and `drop_count` is 0.

Source files
------------

// File: rtl/p4_egress_demux.sv
// Egress demultiplexer for the vitis_net_p4 output stream: steers each packet to the
// egress port named by its metadata word, dropping and counting packets with invalid ports.
module p4_egress_demux #(
   parameter int unsigned TDATA_NUM_BYTES      = 64,
   parameter int unsigned USER_META_DATA_WIDTH = 9,
   parameter int unsigned NUM_PORTS            = 2,
   parameter int unsigned META_FIFO_DEPTH      = 4
) (
   input  logic                                   s_axis_aclk,
   input  logic                                   s_axis_aresetn,
   input  logic [USER_META_DATA_WIDTH-1:0]        user_metadata_in,
   input  logic                                   user_metadata_in_valid,
   input  logic [TDATA_NUM_BYTES*8-1:0]           s_axis_tdata,
   input  logic [TDATA_NUM_BYTES-1:0]             s_axis_tkeep,
   input  logic                                   s_axis_tvalid,
   input  logic                                   s_axis_tlast,
   output logic                                   s_axis_tready,
   output logic [NUM_PORTS*TDATA_NUM_BYTES*8-1:0] m_axis_tdata,
   output logic [NUM_PORTS*TDATA_NUM_BYTES-1:0]   m_axis_tkeep,
   output logic [NUM_PORTS-1:0]                   m_axis_tvalid,
   output logic [NUM_PORTS-1:0]                   m_axis_tlast,
   input  logic [NUM_PORTS-1:0]                   m_axis_tready,
   output logic [31:0]                            drop_count,
   output logic                                   meta_overflow
);

   localparam int unsigned DW = TDATA_NUM_BYTES * 8;
   localparam int unsigned KW = TDATA_NUM_BYTES;
   localparam int unsigned MW = USER_META_DATA_WIDTH;
   localparam int unsigned AW = (META_FIFO_DEPTH > 1) ? $clog2(META_FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FIFO_FULL = CW'(META_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FWD  = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [MW-1:0]   sel_q, sel_d;
   logic [MW-1:0]   mem_q [META_FIFO_DEPTH];
   logic [MW-1:0]   mem_d [META_FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     drop_count_q, drop_count_d;
   logic            overflow_q, overflow_d;

   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            write_en;
   logic            accept_last;
   logic [MW-1:0]   head;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == FIFO_FULL);
   assign head        = mem_q[rd_ptr_q];
   assign accept_last = s_axis_tvalid & s_axis_tready & s_axis_tlast;

   // Payload is broadcast to every port; only the valids are steered.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_bcast
      assign m_axis_tdata[g*DW +: DW] = s_axis_tdata;
      assign m_axis_tkeep[g*KW +: KW] = s_axis_tkeep;
      assign m_axis_tlast[g]          = s_axis_tlast;
   end

   // Routing FSM: next state, selection latch, drop counter and stream handshakes.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      drop_count_d  = drop_count_q;
      pop           = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = '0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sel_d   = head;
               state_d = (32'(head) < NUM_PORTS) ? S_FWD : S_DROP;
            end
         end
         S_FWD: begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
               if (32'(sel_q) == i) begin
                  s_axis_tready    = m_axis_tready[i];
                  m_axis_tvalid[i] = s_axis_tvalid;
               end
            end
            if (accept_last) begin
               state_d = S_IDLE;
            end
         end
         S_DROP: begin
            s_axis_tready = 1'b1;
            if (accept_last) begin
               state_d = S_IDLE;
               if (drop_count_q != '1) begin
                  drop_count_d = drop_count_q + 32'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Metadata FIFO: a push while full succeeds only if the same cycle pops.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      write_en   = user_metadata_in_valid & (~fifo_full | pop);
      overflow_d = overflow_q | (user_metadata_in_valid & fifo_full & ~pop);
      if (write_en) begin
         mem_d[wr_ptr_q] = user_metadata_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(write_en) - CW'(pop);
   end

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state_q      <= S_IDLE;
         sel_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_count_q <= drop_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge s_axis_aclk) begin
      mem_q <= mem_d;
   end

   assign drop_count    = drop_count_q;
   assign meta_overflow = overflow_q;

endmodule
